// File: rtl/regfile_pkg.sv
// Shared widths and constants for the register-file writeback arbiter.
// Port indices are typed so grant bookkeeping reads in design terms.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int ZERO_REG = 0;

  typedef enum logic {
    PORT_ALU  = 1'b0,
    PORT_LOAD = 1'b1
  } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port that did not win last time
// is granted. hold suppresses every grant.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  logic       hold,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (!hold) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == PORT_ALU) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks into a single register-file write port,
// with a one-cycle output stage and same-cycle read bypass.
module regfile_wb_arbiter
  import regfile_pkg::port_e;
  import regfile_pkg::PORT_ALU;
  import regfile_pkg::PORT_LOAD;
  import regfile_pkg::ZERO_REG;
#(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              reg_write_enable,
  output logic [ADDR_W-1:0] reg_write_address,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_register_1,
  input  logic [ADDR_W-1:0] read_register_2,
  output logic              bypass_hit_1,
  output logic              bypass_hit_2,
  output logic [DATA_W-1:0] bypass_data
);

  // Handshake: a port transfers on a rising edge where its valid and ready
  // are both high; ready depends only on hold, the valids and r_rr_last.
  port_e             r_rr_last;
  logic              r_stage_valid;
  logic [ADDR_W-1:0] r_stage_addr;
  logic [DATA_W-1:0] r_stage_data;

  logic [1:0] w_gnt;
  logic [1:0] w_xfer;

  rr_arb2 u_rr_arb2 (
    .req  ({req1_valid, req0_valid}),
    .hold (hold),
    .last (r_rr_last),
    .gnt  (w_gnt)
  );

  assign w_xfer     = w_gnt & {req1_valid, req0_valid};
  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  // Address/data keep their last value when no transfer occurs; only the
  // valid bit drops, so the stage holds a write for exactly one cycle.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_stage_valid <= 1'b0;
      r_stage_addr  <= '0;
      r_stage_data  <= '0;
      r_rr_last     <= PORT_LOAD;
    end else begin
      r_stage_valid <= |w_xfer;
      if (w_xfer[0]) begin
        r_stage_addr <= req0_addr;
        r_stage_data <= req0_data;
        r_rr_last    <= PORT_ALU;
      end else if (w_xfer[1]) begin
        r_stage_addr <= req1_addr;
        r_stage_data <= req1_data;
        r_rr_last    <= PORT_LOAD;
      end
    end
  end

  // Register 0 is hardwired: its writes are accepted but never strobed.
  assign reg_write_enable  = r_stage_valid && (r_stage_addr != ADDR_W'(ZERO_REG));
  assign reg_write_address = r_stage_addr;
  assign write_data        = r_stage_data;

  assign bypass_hit_1 = reg_write_enable && (read_register_1 == r_stage_addr);
  assign bypass_hit_2 = reg_write_enable && (read_register_2 == r_stage_addr);
  assign bypass_data  = r_stage_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter plus hand-written
// reset sequences.
module tb_regfile_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock;
  logic          Reset;
  logic          hold;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          reg_write_enable;
  logic [AW-1:0] reg_write_address;
  logic [DW-1:0] write_data;
  logic [AW-1:0] read_register_1, read_register_2;
  logic          bypass_hit_1, bypass_hit_2;
  logic [DW-1:0] bypass_data;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock             (clock),
    .Reset             (Reset),
    .hold              (hold),
    .req0_valid        (req0_valid),
    .req0_addr         (req0_addr),
    .req0_data         (req0_data),
    .req0_ready        (req0_ready),
    .req1_valid        (req1_valid),
    .req1_addr         (req1_addr),
    .req1_data         (req1_data),
    .req1_ready        (req1_ready),
    .reg_write_enable  (reg_write_enable),
    .reg_write_address (reg_write_address),
    .write_data        (write_data),
    .read_register_1   (read_register_1),
    .read_register_2   (read_register_2),
    .bypass_hit_1      (bypass_hit_1),
    .bypass_hit_2      (bypass_hit_2),
    .bypass_data       (bypass_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One row: inputs applied after an edge; readies are expected for those
  // inputs, stage outputs are expected for the transfer at the previous edge.
  typedef struct {
    logic          hold;
    logic          v0;
    logic          v1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [AW-1:0] rr1;
    logic [AW-1:0] rr2;
    logic          rdy0;
    logic          rdy1;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          hit1;
    logic          hit2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic h, logic v0, logic v1,
                              logic [AW-1:0] a0, logic [DW-1:0] d0,
                              logic [AW-1:0] a1, logic [DW-1:0] d1,
                              logic [AW-1:0] rr1, logic [AW-1:0] rr2,
                              logic rdy0, logic rdy1, logic we,
                              logic [AW-1:0] wa, logic [DW-1:0] wd,
                              logic hit1, logic hit2);
    vec_t v;
    v.hold = h;  v.v0 = v0;  v.v1 = v1;
    v.a0 = a0;   v.d0 = d0;  v.a1 = a1;  v.d1 = d1;
    v.rr1 = rr1; v.rr2 = rr2;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.we = we;
    v.waddr = wa;  v.wdata = wd;  v.hit1 = hit1; v.hit2 = hit2;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic h, input logic v0, input logic v1,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [AW-1:0] rr1, input logic [AW-1:0] rr2);
    hold = h;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    read_register_1 = rr1; read_register_2 = rr2;
  endtask

  task automatic check_outputs(input string tag, input logic rdy0, input logic rdy1,
                               input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic hit1,
                               input logic hit2);
    check({tag, ".req0_ready"}, DW'(req0_ready), DW'(rdy0));
    check({tag, ".req1_ready"}, DW'(req1_ready), DW'(rdy1));
    check({tag, ".reg_write_enable"}, DW'(reg_write_enable), DW'(we));
    check({tag, ".reg_write_address"}, DW'(reg_write_address), DW'(wa));
    check({tag, ".write_data"}, write_data, wd);
    check({tag, ".bypass_hit_1"}, DW'(bypass_hit_1), DW'(hit1));
    check({tag, ".bypass_hit_2"}, DW'(bypass_hit_2), DW'(hit2));
    check({tag, ".bypass_data"}, bypass_data, wd);
  endtask

  task automatic next_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset and idle
    Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clock);
    #2;
    check_outputs("in_reset", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    next_edge();
    Reset = 1'b1;

    //           hold v0 v1 a0  d0            a1  d1      rr1 rr2 rdy0 rdy1 we addr data          h1 h2
    tbl.push_back(mk(0, 0, 0, 0,  32'h0,        0,  32'h0,     0,  0, 0, 0, 0, 0,  32'h0,        0, 0));
    tbl.push_back(mk(0, 1, 1, 3,  32'h11,       4,  32'h22,    0,  0, 1, 0, 0, 0,  32'h0,        0, 0));
    tbl.push_back(mk(0, 1, 0, 5,  32'hDEADBEEF, 0,  32'h0,     3,  4, 1, 0, 1, 3,  32'h11,       1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  32'h0,        0,  32'h0,     0,  0, 0, 0, 1, 5,  32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  32'h0,        0,  32'h0,     5,  5, 0, 0, 0, 5,  32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  32'h0,        0,  32'h1234,  0,  0, 0, 1, 0, 5,  32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  32'h0,        0,  32'h0,     0,  0, 0, 0, 0, 0,  32'h1234,     0, 0));
    tbl.push_back(mk(1, 1, 1, 1,  32'hA1,       2,  32'hB2,    0,  0, 0, 0, 0, 0,  32'h1234,     0, 0));
    tbl.push_back(mk(1, 1, 1, 1,  32'hA1,       2,  32'hB2,    0,  0, 0, 0, 0, 0,  32'h1234,     0, 0));
    tbl.push_back(mk(1, 1, 1, 1,  32'hA1,       2,  32'hB2,    0,  0, 0, 0, 0, 0,  32'h1234,     0, 0));
    tbl.push_back(mk(0, 1, 1, 1,  32'hA1,       2,  32'hB2,    0,  0, 1, 0, 0, 0,  32'h1234,     0, 0));
    tbl.push_back(mk(0, 1, 1, 1,  32'hA1,       2,  32'hB2,    0,  0, 0, 1, 1, 1,  32'hA1,       0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  32'h0,        0,  32'h0,     0,  0, 0, 0, 1, 2,  32'hB2,       0, 0));
    // six-cycle alternation, both ports valid throughout
    tbl.push_back(mk(0, 1, 1, 10, 32'h100,      11, 32'h101,   0,  0, 1, 0, 0, 2,  32'hB2,       0, 0));
    tbl.push_back(mk(0, 1, 1, 12, 32'h200,      11, 32'h101,   0,  0, 0, 1, 1, 10, 32'h100,      0, 0));
    tbl.push_back(mk(0, 1, 1, 12, 32'h200,      13, 32'h300,   0,  0, 1, 0, 1, 11, 32'h101,      0, 0));
    tbl.push_back(mk(0, 1, 1, 14, 32'h400,      13, 32'h300,   0,  0, 0, 1, 1, 12, 32'h200,      0, 0));
    tbl.push_back(mk(0, 1, 1, 14, 32'h400,      15, 32'h500,   0,  0, 1, 0, 1, 13, 32'h300,      0, 0));
    tbl.push_back(mk(0, 1, 1, 16, 32'h600,      15, 32'h500,   0,  0, 0, 1, 1, 14, 32'h400,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  32'h0,        0,  32'h0,     15, 14, 0, 0, 1, 15, 32'h500,     1, 0));
    // bypass on an in-flight write to register 7
    tbl.push_back(mk(0, 1, 0, 7,  32'hCAFEF00D, 0,  32'h0,     7,  8, 1, 0, 0, 15, 32'h500,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  32'h0,        0,  32'h0,     7,  8, 0, 0, 1, 7,  32'hCAFEF00D, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  32'h0,        0,  32'h0,     7,  8, 0, 0, 0, 7,  32'hCAFEF00D, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      next_edge();
      drive(tbl[i].hold, tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].d0,
            tbl[i].a1, tbl[i].d1, tbl[i].rr1, tbl[i].rr2);
      #1;
      check_outputs($sformatf("row%0d", i), tbl[i].rdy0, tbl[i].rdy1, tbl[i].we,
                    tbl[i].waddr, tbl[i].wdata, tbl[i].hit1, tbl[i].hit2);
    end

    // Reset right after a port-0 transfer: the write is discarded and the
    // next tie must again go to port 0.
    next_edge();
    drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h99, '0, '0, 5'd9, '0);
    #1;
    check("mid_rst.req0_ready", DW'(req0_ready), DW'(1'b1));
    next_edge();
    Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd9, '0);
    #1;
    check_outputs("mid_rst.asserted", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    next_edge();
    Reset = 1'b1;
    #1;
    check_outputs("mid_rst.release", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    next_edge();
    check("mid_rst.no_strobe", DW'(reg_write_enable), DW'(1'b0));
    drive(1'b0, 1'b1, 1'b1, 5'd6, 32'h66, 5'd7, 32'h77, '0, '0);
    #1;
    check("mid_rst.tie_rdy0", DW'(req0_ready), DW'(1'b1));
    check("mid_rst.tie_rdy1", DW'(req1_ready), DW'(1'b0));
    next_edge();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd6, '0);
    #1;
    check_outputs("mid_rst.after_tie", 1'b0, 1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The module SHALL take parameter ADDR_W, default 5, as the register address width.
REQ-002 The module SHALL take parameter DATA_W, default 32, as the register data width.
REQ-003 Port clock SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port Reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port hold SHALL be an input, 1 bit wide: pipeline stall; blocks new grants.
REQ-006 Ports req0_valid and req1_valid SHALL be inputs, 1 bit each: write request pending (0 = ALU writeback, 1 = load writeback).
REQ-007 Ports req0_addr and req1_addr SHALL be inputs, ADDR_W bits each: destination register.
REQ-008 Ports req0_data and req1_data SHALL be inputs, DATA_W bits each: write value.
REQ-009 Ports req0_ready and req1_ready SHALL be outputs, 1 bit each: request accepted this cycle.
REQ-010 Port reg_write_enable SHALL be an output, 1 bit wide: register-file write strobe.
REQ-011 Port reg_write_address SHALL be an output, ADDR_W bits: register-file write address.
REQ-012 Port write_data SHALL be an output, DATA_W bits: register-file write data.
REQ-013 Ports read_register_1 and read_register_2 SHALL be inputs, ADDR_W bits each: current read addresses, used for bypass.
REQ-014 Ports bypass_hit_1 and bypass_hit_2 SHALL be outputs, 1 bit each: the matching read must use bypass_data.
REQ-015 Port bypass_data SHALL be an output, DATA_W bits: the in-flight write value.

Function
REQ-016 A transfer SHALL occur on port n when reqn_valid and reqn_ready are both high at a rising edge.
REQ-017 reqn_ready SHALL be combinational from hold, both valids and rr_last; it SHALL never depend on reqn_data or reqn_addr.
REQ-018 When hold is high, both ready outputs SHALL be 0.
REQ-019 When hold is low and exactly one valid is high, that port SHALL be ready.
REQ-020 When hold is low and both valids are high, the port not equal to rr_last SHALL be ready, and only that port.
REQ-021 rr_last SHALL update to the granted port index on every transfer and SHALL hold otherwise.
REQ-022 A transfer SHALL load the output stage (valid bit, address, data) at that edge; latency from transfer edge to reg_write_enable high is 1 cycle.
REQ-023 The output stage SHALL hold its contents for exactly one cycle; with no transfer, its valid bit SHALL clear at the next edge.
REQ-024 reg_write_enable SHALL equal stage valid AND (stage address != 0); a write to register 0 is accepted but never strobed.
REQ-025 reg_write_address and write_data SHALL reflect the stage contents at all times, including while the stage is invalid.
REQ-026 bypass_hit_k SHALL equal reg_write_enable AND (read_register_k == reg_write_address); bypass_data SHALL equal write_data.
REQ-027 Back-to-back transfers SHALL sustain 1 write per cycle with no bubble.
REQ-028 A requester holding valid while hold is low SHALL be granted within 2 cycles (starvation bound).
REQ-029 Request inputs SHALL be required to remain stable while valid is high and ready is low; the arbiter SHALL not check this.

Reset
REQ-030 While Reset is low, the following SHALL hold: stage valid = 0, stage address = 0, stage data = 0, rr_last = 1 (port 0 wins the first tie), reg_write_enable = 0, bypass hits = 0.
REQ-031 Reset assertion mid-transfer SHALL discard the in-flight write; no strobe SHALL be issued after reset releases until a new transfer occurs.

Structure
REQ-032 ADDR_W, DATA_W and ZERO_REG (= 0) SHALL reside in shared package regfile_pkg.
REQ-033 Two-way round-robin grant logic SHALL be a sub-module named rr_arb2, with inputs req[1:0], hold and last, and outputs gnt[1:0].

Verification
REQ-034 The bench SHALL check: Reset low, then release -> all outputs 0; first tie with both valid grants port 0.
REQ-035 The bench SHALL check: req0 valid, addr=5, data=0xDEADBEEF, for 1 cycle -> next cycle reg_write_enable=1, address=5, data=0xDEADBEEF; enable=0 the following cycle.
REQ-036 The bench SHALL check: both ports valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1 with 6 consecutive strobes.
REQ-037 The bench SHALL check: req1 valid, addr=0, data=0x1234 -> ready=1, reg_write_enable stays 0, bypass hits stay 0.
REQ-038 The bench SHALL check: hold=1 for 3 cycles with both ports valid -> no readies and no strobes; on hold=0, grant resumes per rr_last.
REQ-039 The bench SHALL check: in-flight write to addr 7 with read_register_1=7 and read_register_2=8 -> bypass_hit_1=1, bypass_hit_2=0, bypass_data equals the written value.
